// File: rtl/idct_4point_seq.sv
// 4-point inverse DCT (x = C^T * X, Q4 matrix) using one time-multiplexed signed MAC over 16 cycles.
// Build option: define IDCT_SATURATE_EN to clamp outputs to the OUT_W signed range; otherwise they wrap.
module idct_4point_seq #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8
) (
    input  logic                    i_clk,
    input  logic                    i_clr,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [IN_W-1:0]  i_data0,
    input  logic signed [IN_W-1:0]  i_data1,
    input  logic signed [IN_W-1:0]  i_data2,
    input  logic signed [IN_W-1:0]  i_data3,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [OUT_W-1:0] o_data0,
    output logic signed [OUT_W-1:0] o_data1,
    output logic signed [OUT_W-1:0] o_data2,
    output logic signed [OUT_W-1:0] o_data3
);
    localparam int PROD_W = IN_W + 8;
    localparam int ACC_W  = IN_W + 10;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (SHIFT - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state;
    logic signed [IN_W-1:0]   x_r [4];
    logic [1:0]               n_cnt;
    logic [1:0]               k_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [7:0]        coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [OUT_W-1:0]  res;
    logic signed [OUT_W-1:0]  out_r [4];

    always_comb begin
        coef = 8'sd0;
        case ({k_cnt, n_cnt})
            4'h0, 4'h1, 4'h2, 4'h3: coef = 8'sd8;
            4'h4: coef = 8'sd10;
            4'h5: coef = 8'sd4;
            4'h6: coef = -8'sd4;
            4'h7: coef = -8'sd10;
            4'h8: coef = 8'sd8;
            4'h9: coef = -8'sd8;
            4'hA: coef = -8'sd8;
            4'hB: coef = 8'sd8;
            4'hC: coef = 8'sd4;
            4'hD: coef = -8'sd10;
            4'hE: coef = 8'sd10;
            4'hF: coef = -8'sd4;
            default: coef = 8'sd0;
        endcase
    end

    // Partial sum including this cycle's product; rounding is applied to it directly on the k==3 edge.
    always_comb begin
        prod = coef * x_r[k_cnt];
        sum  = (k_cnt == 2'd0) ? ACC_W'(prod) : acc + ACC_W'(prod);
        rnd  = (sum + HALF) >>> SHIFT;
`ifdef IDCT_SATURATE_EN
        if (rnd > ACC_W'((1 <<< (OUT_W - 1)) - 1))
            res = {1'b0, {(OUT_W-1){1'b1}}};
        else if (rnd < ACC_W'(-(1 <<< (OUT_W - 1))))
            res = {1'b1, {(OUT_W-1){1'b0}}};
        else
            res = OUT_W'(rnd);
`else
        res = OUT_W'(rnd);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            state   <= IDLE;
            n_cnt   <= '0;
            k_cnt   <= '0;
            acc     <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) out_r[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        x_r[0]  <= i_data0;
                        x_r[1]  <= i_data1;
                        x_r[2]  <= i_data2;
                        x_r[3]  <= i_data3;
                        n_cnt   <= '0;
                        k_cnt   <= '0;
                        o_ready <= 1'b0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc   <= sum;
                    k_cnt <= k_cnt + 2'd1;
                    if (k_cnt == 2'd3) begin
                        out_r[n_cnt] <= res;
                        n_cnt        <= n_cnt + 2'd1;
                        if (n_cnt == 2'd3) begin
                            o_valid <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_data0 = out_r[0];
    assign o_data1 = out_r[1];
    assign o_data2 = out_r[2];
    assign o_data3 = out_r[3];

endmodule
